// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, data width and state encoding.
// Imported by the arbiter top level.
package dmem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // Bit positions in the one-hot grant vector
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic {
        ARB_S   = 1'b0,
        BURST_S = 1'b1
    } arb_state_e;

    // Memory is word-organised: drop the byte offset
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: cpu has fixed priority, dma gets a
// starvation guard and an optional burst lock. Grants are combinational, load data is registered.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_cpu_req,
    input  logic            i_cpu_we,
    input  logic [XLEN-1:0] i_cpu_addr,
    input  logic [XLEN-1:0] i_cpu_wdata,
    output logic            o_cpu_gnt,
    output logic            o_cpu_stall,
    output logic            o_cpu_rvalid,
    output logic [XLEN-1:0] o_cpu_rdata,

    input  logic            i_dma_req,
    input  logic            i_dma_we,
    input  logic [XLEN-1:0] i_dma_addr,
    input  logic [XLEN-1:0] i_dma_wdata,
    input  logic            i_dma_lock,
    output logic            o_dma_gnt,
    output logic            o_dma_rvalid,
    output logic [XLEN-1:0] o_dma_rdata,

    output logic [XLEN-1:0] o_mem_adr,
    output logic [XLEN-1:0] o_mem_wd,
    output logic            o_mem_write,
    input  logic [XLEN-1:0] i_mem_rd
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    arb_state_e    r_state;
    logic          r_force_cpu;
    logic [WW-1:0] r_wait_cnt;
    logic [BW-1:0] r_burst_cnt;

    logic            r_cpu_rvalid;
    logic [XLEN-1:0] r_cpu_rdata;
    logic            r_dma_rvalid;
    logic [XLEN-1:0] r_dma_rdata;

    logic [1:0]    w_gnt;
    logic          w_wait_full;
    logic          w_in_burst;
    logic          w_lock_start;
    logic          w_burst_grant;
    logic          w_burst_done;
    logic [BW-1:0] w_burst_cnt_nxt;
    logic          w_cpu_load;
    logic          w_dma_load;

    assign w_wait_full = (r_wait_cnt == WW'(MAX_WAIT));

    // A burst only holds while dma keeps both req and lock; otherwise this cycle is arbitrated
    // exactly as in ARB_S.
    assign w_in_burst = (r_state == BURST_S) & i_dma_req & i_dma_lock;

    always_comb begin
        w_gnt = '0;
        if (!i_rst) begin
            if (w_in_burst) begin
                w_gnt[PORT_DMA] = 1'b1;
            end else if (r_force_cpu & i_cpu_req) begin
                w_gnt[PORT_CPU] = 1'b1;
            end else if (i_dma_req & (~i_cpu_req | w_wait_full)) begin
                w_gnt[PORT_DMA] = 1'b1;
            end else if (i_cpu_req) begin
                w_gnt[PORT_CPU] = 1'b1;
            end
        end
    end

    // The cycle right after a burst-limit exit may not start a new burst.
    assign w_lock_start    = w_gnt[PORT_DMA] & ~w_in_burst & i_dma_lock & ~r_force_cpu;
    assign w_burst_grant   = w_in_burst | w_lock_start;
    assign w_burst_cnt_nxt = w_in_burst ? (r_burst_cnt + BW'(1)) : BW'(1);
    assign w_burst_done    = w_burst_grant & (w_burst_cnt_nxt == BW'(MAX_BURST));

    assign w_cpu_load = w_gnt[PORT_CPU] & ~i_cpu_we;
    assign w_dma_load = w_gnt[PORT_DMA] & ~i_dma_we;

    assign o_cpu_gnt   = w_gnt[PORT_CPU];
    assign o_dma_gnt   = w_gnt[PORT_DMA];
    assign o_cpu_stall = i_cpu_req & ~w_gnt[PORT_CPU];

    always_comb begin
        o_mem_adr   = '0;
        o_mem_wd    = '0;
        o_mem_write = 1'b0;
        if (w_gnt[PORT_CPU]) begin
            o_mem_adr   = word_addr(i_cpu_addr);
            o_mem_wd    = i_cpu_wdata;
            o_mem_write = i_cpu_we;
        end else if (w_gnt[PORT_DMA]) begin
            o_mem_adr   = word_addr(i_dma_addr);
            o_mem_wd    = i_dma_wdata;
            o_mem_write = i_dma_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (i_dma_req & ~w_gnt[PORT_DMA]) begin
                if (!w_wait_full) begin
                    r_wait_cnt <= r_wait_cnt + WW'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end
            r_burst_cnt <= (w_burst_grant & ~w_burst_done) ? w_burst_cnt_nxt : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ARB_S;
            r_force_cpu <= 1'b0;
        end else begin
            r_force_cpu <= w_burst_done;
            if (w_burst_grant & ~w_burst_done) begin
                r_state <= BURST_S;
            end else begin
                r_state <= ARB_S;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_load;
            r_dma_rvalid <= w_dma_load;
            if (w_cpu_load) begin
                r_cpu_rdata <= i_mem_rd;
            end
            if (w_dma_load) begin
                r_dma_rdata <= i_mem_rd;
            end
        end
    end

    // A response pending when reset arrives is dropped, not delivered.
    assign o_cpu_rvalid = r_cpu_rvalid & ~i_rst;
    assign o_dma_rvalid = r_dma_rvalid & ~i_rst;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all checked each cycle
// against a rule-level reference model and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_adr, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_stall  (cpu_stall),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .i_dma_req    (dma_req),
        .i_dma_we     (dma_we),
        .i_dma_addr   (dma_addr),
        .i_dma_wdata  (dma_wdata),
        .i_dma_lock   (dma_lock),
        .o_dma_gnt    (dma_gnt),
        .o_dma_rvalid (dma_rvalid),
        .o_dma_rdata  (dma_rdata),
        .o_mem_adr    (mem_adr),
        .o_mem_wd     (mem_wd),
        .o_mem_write  (mem_write),
        .i_mem_rd     (mem_rd)
    );

    // Data_memory stand-in: combinational read, write at the clock edge
    logic        mem_clr;
    logic [31:0] tb_mem [256];
    assign mem_rd = tb_mem[mem_adr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) tb_mem[k] <= '0;
        end else if (mem_write) begin
            tb_mem[mem_adr[9:2]] <= mem_wd;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state, in terms of the arbitration rules
    logic [31:0] ref_mem [256];
    int          m_waited;
    bit          m_owns;
    int          m_beats;
    bit          m_cpu_turn;
    bit          m_burst_on;
    bit          m_cpu_rv, m_dma_rv;
    logic [31:0] m_cpu_rd, m_dma_rd;
    bit          e_cpu, e_dma;

    bit          last_cpu_gnt, last_dma_gnt, last_cpu_rvalid, last_dma_rvalid;
    logic [31:0] last_cpu_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_arb();
        e_cpu = 1'b0;
        e_dma = 1'b0;
        m_burst_on = m_owns && dma_lock && dma_req;
        if (rst) return;
        if (m_burst_on) e_dma = 1'b1;
        else if (m_cpu_turn && cpu_req) e_cpu = 1'b1;
        else if (dma_req && (!cpu_req || m_waited >= MAX_WAIT)) e_dma = 1'b1;
        else if (cpu_req) e_cpu = 1'b1;
    endfunction

    function automatic void model_commit();
        bit next_turn;
        if (rst) begin
            m_waited = 0; m_owns = 0; m_beats = 0; m_cpu_turn = 0;
            m_cpu_rv = 0; m_dma_rv = 0; m_cpu_rd = '0; m_dma_rd = '0;
            return;
        end
        m_cpu_rv = e_cpu && !cpu_we;
        m_dma_rv = e_dma && !dma_we;
        if (m_cpu_rv) m_cpu_rd = ref_mem[cpu_addr[9:2]];
        if (m_dma_rv) m_dma_rd = ref_mem[dma_addr[9:2]];
        if (e_cpu && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        if (e_dma && dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
        next_turn = 1'b0;
        if (e_dma && (m_burst_on || (dma_lock && !m_cpu_turn))) begin
            m_beats = m_burst_on ? m_beats + 1 : 1;
            if (m_beats >= MAX_BURST) begin
                m_owns = 0; m_beats = 0; next_turn = 1'b1;
            end else begin
                m_owns = 1;
            end
        end else begin
            m_owns = 0; m_beats = 0;
        end
        m_cpu_turn = next_turn;
        if (dma_req && !e_dma) m_waited = (m_waited < MAX_WAIT) ? m_waited + 1 : MAX_WAIT;
        else m_waited = 0;
    endfunction

    task automatic cycle();
        logic [31:0] exp_adr, exp_wd;
        @(negedge clk);
        model_arb();
        exp_adr = e_cpu ? (cpu_addr & ~32'd3) : (e_dma ? (dma_addr & ~32'd3) : 32'd0);
        exp_wd  = e_cpu ? cpu_wdata : (e_dma ? dma_wdata : 32'd0);
        chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cpu));
        chk("dma_gnt",    32'(dma_gnt),    32'(e_dma));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !e_cpu));
        chk("mem_write",  32'(mem_write),  32'((e_cpu && cpu_we) || (e_dma && dma_we)));
        chk("mem_adr",    mem_adr,         exp_adr);
        chk("mem_wd",     mem_wd,          exp_wd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv && !rst));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_dma_rv && !rst));
        chk("cpu_rdata",  cpu_rdata,       m_cpu_rd);
        chk("dma_rdata",  dma_rdata,       m_dma_rd);
        last_cpu_gnt    = cpu_gnt;
        last_dma_gnt    = dma_gnt;
        last_cpu_rvalid = cpu_rvalid;
        last_dma_rvalid = dma_rvalid;
        last_cpu_rdata  = cpu_rdata;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
    endtask

    initial begin
        int dma_cnt, run, max_run, run_end;
        bit cpu_hist [40];
        bit dma_hist [40];

        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        m_waited = 0; m_owns = 0; m_beats = 0; m_cpu_turn = 0;
        m_cpu_rv = 0; m_dma_rv = 0; m_cpu_rd = '0; m_dma_rd = '0;

        // Reset with requests present: nothing may be granted or written
        idle_inputs();
        rst = 1; mem_clr = 1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678;
        cycle();
        idle_inputs();
        rst = 0;
        repeat (2) cycle();

        // Store then load the same word
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
        cycle();
        cpu_we = 0; cpu_addr = 32'h42;
        cycle();
        idle_inputs();
        cycle();
        chk("st_ld_rvalid", 32'(last_cpu_rvalid), 32'd1);
        chk("st_ld_rdata",  last_cpu_rdata,       32'hDEAD_BEEF);

        // Both ports requesting continuously: dma gets one slot in every MAX_WAIT+1
        cycle();
        cpu_req = 1; cpu_addr = 32'h44; dma_req = 1; dma_addr = 32'h88;
        dma_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_dma_gnt) dma_cnt++;
        end
        chk("dma_share", dma_cnt, 20 / (MAX_WAIT + 1));

        // Locked dma burst against a persistent cpu request
        idle_inputs();
        cycle();
        cpu_req = 1; cpu_addr = 32'h48; dma_req = 1; dma_lock = 1; dma_we = 1;
        for (int i = 0; i < 40; i++) begin
            dma_addr = 32'h100 + 32'(4 * i); dma_wdata = $urandom;
            cycle();
            cpu_hist[i] = last_cpu_gnt;
            dma_hist[i] = last_dma_gnt;
        end
        run = 0; max_run = 0; run_end = 0;
        for (int i = 0; i < 40; i++) begin
            run = dma_hist[i] ? run + 1 : 0;
            if (run > max_run) begin max_run = run; run_end = i; end
        end
        chk("burst_len", max_run, MAX_BURST);
        chk("burst_cpu_after", 32'(cpu_hist[(run_end + 1) % 40]), 32'd1);

        // dma load granted, reset on the next cycle: the response must be dropped
        idle_inputs();
        cycle();
        dma_req = 1; dma_addr = 32'h80;
        cycle();
        chk("rst_dma_gnt", 32'(last_dma_gnt), 32'd1);
        dma_req = 0; rst = 1;
        cycle();
        chk("rst_rvalid_a", 32'(last_dma_rvalid), 32'd0);
        rst = 0;
        cycle();
        chk("rst_rvalid_b", 32'(last_dma_rvalid), 32'd0);
        cpu_req = 1; dma_req = 1; dma_lock = 1;
        cycle();
        chk("rst_arb_cpu", 32'(last_cpu_gnt), 32'd1);

        // Lock dropped after three beats: the waiting cpu gets the very next slot
        idle_inputs();
        cycle();
        dma_req = 1; dma_lock = 1; dma_addr = 32'h200;
        cycle();
        cpu_req = 1; cpu_addr = 32'h204;
        cycle();
        cycle();
        chk("beat3_dma", 32'(last_dma_gnt), 32'd1);
        dma_lock = 0;
        cycle();
        chk("unlock_cpu", 32'(last_cpu_gnt), 32'd1);

        // Random traffic, including mid-stream resets
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            dma_req   = ($urandom_range(0, 2) != 0);
            dma_we    = $urandom_range(0, 1) == 1;
            dma_addr  = $urandom;
            dma_wdata = $urandom;
            dma_lock  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
